cpu_reg_axil_slave: RTL and testbench

- AXI4-Lite slave register bank; the responder side of the AXI4-Lite master VIP used in the cpu_reg bench.
- Four 32-bit RW registers at 0x00..0x0C, a read-only status word and a read-only version word.
- Register contents exported to fabric logic, plus per-register write strobes.
- Sits under the cpu_reg IP top and is driven directly by the VIP master in bench.

---
 rtl/cpu_reg_axil_slave.sv | 146 ++++++++++++++
 tb/tb_cpu_reg_axil_slave.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_reg_axil_slave.sv
// AXI4-Lite register bank: four RW words, a sampled status word and a constant version word.
// Optional build macro CPU_REG_SLVERR_EN: SLVERR on unmapped accesses and on writes to read-only words.
module cpu_reg_axil_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION            = 32'h0001_0000
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in,
    output logic [3:0]                        wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int NBYTE = DW / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef CPU_REG_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    logic [3:0][DW-1:0] regs;
    logic               act;
    logic               aw_full, w_full;
    logic [2:0]         aw_idx;
    logic [DW-1:0]      w_data;
    logic [NBYTE-1:0]   w_strb;
    logic               aw_hs, w_hs, ar_hs, commit;
    logic [2:0]         ar_idx;
    logic [DW-1:0]      rd_data, wr_merged;
    logic [1:0]         rd_resp, wr_resp;
    logic               unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // act keeps every READY low for the cycle following a reset edge
    assign S_AXI_AWREADY = act && !aw_full && !S_AXI_BVALID;
    assign S_AXI_WREADY  = act && !w_full  && !S_AXI_BVALID;
    assign S_AXI_ARREADY = act && !S_AXI_RVALID;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_full && w_full;
    assign ar_idx = S_AXI_ARADDR[4:2];

    assign reg_out = regs;

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (ar_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_data = regs[ar_idx[1:0]];
            3'd4:                   rd_data = status_in;
            3'd5:                   rd_data = VERSION;
            default:                rd_resp = SLVERR_EN ? RESP_SLVERR : RESP_OKAY;
        endcase
    end

    always_comb begin
        wr_merged = regs[aw_idx[1:0]];
        for (int b = 0; b < NBYTE; b++) begin
            if (w_strb[b]) wr_merged[8*b +: 8] = w_data[8*b +: 8];
        end
        // 0x10..0x1C are never writable: status, version, unmapped
        wr_resp = (SLVERR_EN && aw_idx[2]) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            regs         <= '0;
            act          <= 1'b0;
            aw_full      <= 1'b0;
            w_full       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            wr_pulse     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else begin
            act      <= 1'b1;
            wr_pulse <= '0;
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= S_AXI_WDATA;
                w_strb <= S_AXI_WSTRB;
            end
            // both flags full implies both READYs low, so no accept can race the commit
            if (commit) begin
                aw_full      <= 1'b0;
                w_full       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_resp;
                if (!aw_idx[2]) begin
                    regs[aw_idx[1:0]]     <= wr_merged;
                    wr_pulse[aw_idx[1:0]] <= 1'b1;
                end
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_data;
            S_AXI_RRESP  <= rd_resp;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_reg_axil_slave.sv
// Randomized self-checking bench for cpu_reg_axil_slave against an array-based register model.
module tb_cpu_reg_axil_slave;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic [4:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [4:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [127:0] reg_out;
    logic [31:0]  status_in = '0;
    logic [3:0]   wr_pulse;

    int checks = 0;
    int failures = 0;
    logic [31:0] m [4];

    localparam logic [31:0] VER = 32'h0001_0000;
`ifdef CPU_REG_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    cpu_reg_axil_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [127:0] exp_regs();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic [31:0] st);
        case (a[4:2])
            3'd0, 3'd1, 3'd2, 3'd3: return m[a[3:2]];
            3'd4:                   return st;
            3'd5:                   return VER;
            default:                return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] exp_rresp(input logic [4:0] a);
        return (SLV && a[4:3] == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] exp_bresp(input logic [4:0] a);
        return (SLV && a[4]) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [3:0] exp_pulse(input logic [4:0] a);
        return a[4] ? 4'b0000 : (4'b0001 << a[3:2]);
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        logic [1:0] br;
        logic [3:0] ep;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            if (cyc > 60) begin
                checks++; failures++;
                $display("FAIL wr_handshake_timeout addr=%h aw_done=%0d w_done=%0d", a, aw_done, w_done);
                S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
                return;
            end
            S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
            S_AXI_WVALID  = !w_done && cyc >= w_dly;
            if (aw_done != w_done) begin
                checks++;
                if (S_AXI_AWREADY !== !aw_done || S_AXI_WREADY !== !w_done) begin
                    failures++;
                    $display("FAIL half_accept_ready got aw=%b w=%b exp aw=%b w=%b",
                             S_AXI_AWREADY, S_AXI_WREADY, !aw_done, !w_done);
                end
            end
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge ACLK);
            aw_done |= aw_hs; w_done |= w_hs; cyc++;
        end
        if (!a[4]) for (int b = 0; b < 4; b++) if (s[b]) m[a[3:2]][8*b +: 8] = d[8*b +: 8];
        ep = exp_pulse(a);
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        checks++;
        if (S_AXI_BVALID !== 1'b0) begin
            failures++; $display("FAIL bvalid_early got=%b exp=0", S_AXI_BVALID);
        end
        @(negedge ACLK);
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin
            failures++; $display("FAIL bvalid_latency got=%b exp=1", S_AXI_BVALID);
        end
        checks++;
        if (S_AXI_BRESP !== exp_bresp(a)) begin
            failures++; $display("FAIL bresp addr=%h got=%b exp=%b", a, S_AXI_BRESP, exp_bresp(a));
        end
        checks++;
        if (wr_pulse !== ep) begin
            failures++; $display("FAIL wr_pulse addr=%h got=%b exp=%b", a, wr_pulse, ep);
        end
        checks++;
        if (reg_out !== exp_regs()) begin
            failures++; $display("FAIL reg_out got=%h exp=%h", reg_out, exp_regs());
        end
        br = S_AXI_BRESP;
        for (int i = 0; i < b_dly; i++) begin
            S_AXI_AWVALID = 1;  // a second AW must be refused while B is pending
            @(negedge ACLK);
            checks++;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== br || S_AXI_AWREADY !== 1'b0 ||
                S_AXI_WREADY !== 1'b0 || wr_pulse !== 4'b0) begin
                failures++;
                $display("FAIL b_hold got bvalid=%b bresp=%b awready=%b wready=%b pulse=%b exp 1 %b 0 0 0000",
                         S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY, wr_pulse, br);
            end
        end
        S_AXI_AWVALID = 0; S_AXI_BREADY = 1;
        @(negedge ACLK);
        S_AXI_BREADY = 0;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || wr_pulse !== 4'b0) begin
            failures++; $display("FAIL b_clear got bvalid=%b pulse=%b exp 0 0000", S_AXI_BVALID, wr_pulse);
        end
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] st, input int ar_dly, input int r_dly);
        bit hs = 0;
        int cyc = 0;
        logic [31:0] ed;
        logic [1:0] er;
        S_AXI_ARADDR = a; status_in = st;
        while (!hs) begin
            @(negedge ACLK);
            if (cyc > 60) begin
                checks++; failures++;
                $display("FAIL rd_handshake_timeout addr=%h", a);
                S_AXI_ARVALID = 0;
                return;
            end
            S_AXI_ARVALID = cyc >= ar_dly;
            hs = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK);
            cyc++;
        end
        ed = exp_rd(a, st); er = exp_rresp(a);
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        status_in = $urandom;  // later status changes must not leak into held RDATA
        checks++;
        if (S_AXI_RVALID !== 1'b1) begin
            failures++; $display("FAIL rvalid_latency got=%b exp=1", S_AXI_RVALID);
        end
        checks++;
        if (S_AXI_RDATA !== ed) begin
            failures++; $display("FAIL rdata addr=%h got=%h exp=%h", a, S_AXI_RDATA, ed);
        end
        checks++;
        if (S_AXI_RRESP !== er) begin
            failures++; $display("FAIL rresp addr=%h got=%b exp=%b", a, S_AXI_RRESP, er);
        end
        for (int i = 0; i < r_dly; i++) begin
            @(negedge ACLK);
            checks++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== ed || S_AXI_RRESP !== er || S_AXI_ARREADY !== 1'b0) begin
                failures++;
                $display("FAIL r_hold got rvalid=%b rdata=%h rresp=%b arready=%b exp 1 %h %b 0",
                         S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY, ed, er);
            end
        end
        S_AXI_RREADY = 1;
        @(negedge ACLK);
        S_AXI_RREADY = 0;
        checks++;
        if (S_AXI_RVALID !== 1'b0) begin
            failures++; $display("FAIL r_clear got=%b exp=0", S_AXI_RVALID);
        end
    endtask

    task automatic test_reset();
        ARESETN = 0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
            failures++;
            $display("FAIL reset_handshake got=%b exp=00000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
        end
        checks++;
        if (reg_out !== 128'h0 || wr_pulse !== 4'b0 || S_AXI_RDATA !== 32'h0 ||
            S_AXI_BRESP !== 2'b0 || S_AXI_RRESP !== 2'b0) begin
            failures++;
            $display("FAIL reset_state got regs=%h pulse=%b rdata=%h bresp=%b rresp=%b exp all 0",
                     reg_out, wr_pulse, S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP);
        end
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        ARESETN = 1;
        @(negedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            failures++;
            $display("FAIL idle_ready got=%b exp=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) axi_write(5'(4*i), 32'(i+1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(5'(4*i), $urandom, 0, 0);
        checks++;
        if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
            failures++; $display("FAIL basic_reg_out got=%h exp=%h", reg_out,
                                 128'h00000004_00000003_00000002_00000001);
        end
    endtask

    task automatic test_aw_first();
        axi_write(5'h04, 32'hDEADBEEF, 4'hF, 0, 3, 0);
        axi_read(5'h04, $urandom, 0, 1);
    endtask

    task automatic test_w_first();
        axi_write(5'h0C, 32'h0BADF00D, 4'hF, 2, 0, 0);
        axi_read(5'h0C, $urandom, 0, 0);
    endtask

    task automatic test_strobe();
        axi_write(5'h08, 32'h0, 4'hF, 0, 0, 0);
        axi_write(5'h08, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        axi_read(5'h08, $urandom, 0, 0);
        checks++;
        if (reg_out[95:64] !== 32'h00BB00DD) begin
            failures++; $display("FAIL strobe_merge got=%h exp=%h", reg_out[95:64], 32'h00BB00DD);
        end
        axi_write(5'h08, 32'h12345678, 4'b0000, 0, 0, 0);
        axi_read(5'h08, $urandom, 1, 0);
    endtask

    task automatic test_bready_hold();
        axi_write(5'h00, 32'h5A5A_0001, 4'hF, 0, 0, 5);
        axi_read(5'h00, $urandom, 0, 3);
    endtask

    task automatic test_status_version();
        axi_read(5'h10, 32'h12345678, 0, 0);
        axi_read(5'h14, $urandom, 0, 0);
        axi_read(5'h18, $urandom, 0, 0);
        axi_read(5'h1C, $urandom, 0, 2);
        axi_write(5'h10, $urandom, 4'hF, 0, 0, 0);
        axi_write(5'h14, $urandom, 4'hF, 1, 0, 0);
        axi_write(5'h1B, $urandom, 4'hF, 0, 1, 1);
        axi_read(5'h14, $urandom, 0, 0);
    endtask

    task automatic test_same_edge();
        logic [31:0] old_v, new_v;
        old_v = m[1]; new_v = $urandom;
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h04; S_AXI_WDATA = new_v; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        S_AXI_ARADDR = 5'h04; S_AXI_ARVALID = 1;
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== old_v) begin
            failures++; $display("FAIL same_edge_read got rvalid=%b rdata=%h exp 1 %h",
                                 S_AXI_RVALID, S_AXI_RDATA, old_v);
        end
        checks++;
        if (S_AXI_BVALID !== 1'b1 || reg_out[63:32] !== new_v) begin
            failures++; $display("FAIL same_edge_write got bvalid=%b reg1=%h exp 1 %h",
                                 S_AXI_BVALID, reg_out[63:32], new_v);
        end
        m[1] = new_v;
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        @(negedge ACLK);
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) begin
            failures++; $display("FAIL same_edge_clear got bvalid=%b rvalid=%b exp 0 0",
                                 S_AXI_BVALID, S_AXI_RVALID);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                axi_write(5'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2));
            else
                axi_read(5'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        @(negedge ACLK);
        S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h5; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        @(negedge ACLK);
        checks++;
        if (S_AXI_BVALID !== 1'b1 || reg_out[31:0] !== 32'h5) begin
            failures++; $display("FAIL pre_reset got bvalid=%b reg0=%h exp 1 5", S_AXI_BVALID, reg_out[31:0]);
        end
        ARESETN = 0;
        @(negedge ACLK);
        checks++;
        if (S_AXI_BVALID !== 1'b0 || reg_out !== 128'h0 || wr_pulse !== 4'b0) begin
            failures++; $display("FAIL mid_reset got bvalid=%b regs=%h pulse=%b exp 0 0 0",
                                 S_AXI_BVALID, reg_out, wr_pulse);
        end
        ARESETN = 1;
        for (int i = 0; i < 4; i++) m[i] = 32'h0;
        axi_write(5'h00, 32'hC0FFEE01, 4'hF, 0, 0, 0);
        axi_read(5'h00, $urandom, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_aw_first();
        test_w_first();
        test_strobe();
        test_bready_hold();
        test_status_version();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
